// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment bus order is {a,b,c,d,e,f,g,dp}, active-low (0 = lit).
package ssd_pkg;

  localparam int unsigned SEG_W = 8;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_OFF = 8'hFF;

  // Hex glyphs in {a..g}, active-low
  localparam logic [6:0] SEG_HEX_0 = 7'b0000001;
  localparam logic [6:0] SEG_HEX_1 = 7'b1001111;
  localparam logic [6:0] SEG_HEX_2 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_3 = 7'b0000110;
  localparam logic [6:0] SEG_HEX_4 = 7'b1001100;
  localparam logic [6:0] SEG_HEX_5 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_6 = 7'b0100000;
  localparam logic [6:0] SEG_HEX_7 = 7'b0001111;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0000100;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b1100000;
  localparam logic [6:0] SEG_HEX_C = 7'b0110001;
  localparam logic [6:0] SEG_HEX_D = 7'b1000010;
  localparam logic [6:0] SEG_HEX_E = 7'b0110000;
  localparam logic [6:0] SEG_HEX_F = 7'b0111000;

  // Append the active-low decimal point to a glyph
  function automatic seg_t seg_pack(input logic [6:0] glyph, input logic dp_lit);
    return {glyph, ~dp_lit};
  endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational hex nibble + decimal point to active-low segment bus.
// Ports: nibble (4-bit value), dp (1 = point lit), seg_c (segment bus).
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output seg_t       seg_c
);

  logic [6:0] glyph;

  // Glyph lookup
  always_comb begin
    glyph = SEG_HEX_8;
    unique case (nibble)
      4'h0: glyph = SEG_HEX_0;
      4'h1: glyph = SEG_HEX_1;
      4'h2: glyph = SEG_HEX_2;
      4'h3: glyph = SEG_HEX_3;
      4'h4: glyph = SEG_HEX_4;
      4'h5: glyph = SEG_HEX_5;
      4'h6: glyph = SEG_HEX_6;
      4'h7: glyph = SEG_HEX_7;
      4'h8: glyph = SEG_HEX_8;
      4'h9: glyph = SEG_HEX_9;
      4'hA: glyph = SEG_HEX_A;
      4'hB: glyph = SEG_HEX_B;
      4'hC: glyph = SEG_HEX_C;
      4'hD: glyph = SEG_HEX_D;
      4'hE: glyph = SEG_HEX_E;
      4'hF: glyph = SEG_HEX_F;
    endcase
  end

  assign seg_c = seg_pack(glyph, dp);

endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver. Captures a packed hex
// value with per-digit decimal points and scans it one digit per refresh slot,
// swapping in new values only at frame boundaries so the display never tears.
// Ports: clk, rst_n (async active-low), bin/dp_in/load (value capture),
//        D_ssd (active-low segments), d (active-low digit enables),
//        pending (captured value awaiting boundary), frame_done (boundary pulse).
// Build option: SSD_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned DIV_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*DIGITS-1:0] bin,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic                load,
  output seg_t                D_ssd,
  output logic [DIGITS-1:0]   d,
  output logic                pending,
  output logic                frame_done
);

  localparam int unsigned IDX_W = $clog2(DIGITS);
  localparam int unsigned BIN_W = 4 * DIGITS;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [DIV_BITS-1:0] div;
  logic [IDX_W-1:0]    idx;
  logic                running;
  logic [BIN_W-1:0]    stage_bin;
  logic [DIGITS-1:0]   stage_dp;
  logic [BIN_W-1:0]    shadow_bin;
  logic [DIGITS-1:0]   shadow_dp;

  logic                tick;
  logic                boundary;
  logic [IDX_W-1:0]    idx_adv;
  logic [BIN_W-1:0]    shadow_bin_nxt;
  logic [DIGITS-1:0]   shadow_dp_nxt;
  logic                pending_nxt;

  logic [3:0]          nib;
  logic                dp_sel;
  logic                idx_valid;
  logic                blank;
  seg_t                dec_seg;
  seg_t                seg_disp;
  logic [DIGITS-1:0]   d_disp;

  // Slot timing, index advance and frame-boundary value transfer.
  // The first tick after reset lights digit 0 instead of stepping past it.
  always_comb begin
    tick           = &div;
    boundary       = tick && running && (idx == IDX_LAST);
    idx_adv        = idx;
    shadow_bin_nxt = shadow_bin;
    shadow_dp_nxt  = shadow_dp;
    pending_nxt    = pending;

    if (tick && running) begin
      idx_adv = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end

    if (boundary) begin
      pending_nxt = 1'b0;
      if (load) begin
        shadow_bin_nxt = bin;
        shadow_dp_nxt  = dp_in;
      end else if (pending) begin
        shadow_bin_nxt = stage_bin;
        shadow_dp_nxt  = stage_dp;
      end
    end else if (load) begin
      pending_nxt = 1'b1;
    end
  end

  // Select the digit about to be shown; uses the post-boundary shadow so
  // a fresh frame starts with the new value on digit 0.
  always_comb begin
    nib       = 4'h0;
    dp_sel    = 1'b0;
    idx_valid = 1'b0;
    blank     = 1'b0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if ({1'b0, idx_adv} == (IDX_W + 1)'(k)) begin
        nib       = shadow_bin_nxt[4*k +: 4];
        dp_sel    = shadow_dp_nxt[k];
        idx_valid = 1'b1;
      end
    end
`ifdef SSD_LEADING_ZERO_BLANK_EN
    begin : lead_zero
      logic zero_run;
      zero_run = 1'b1;
      // Walk from the most significant digit down; digit 0 is never blanked
      for (int k = int'(DIGITS) - 1; k > 0; k--) begin
        zero_run = zero_run && (shadow_bin_nxt[4*k +: 4] == 4'h0);
        if ({1'b0, idx_adv} == (IDX_W + 1)'(k)) begin
          blank = zero_run && !shadow_dp_nxt[k];
        end
      end
    end
`endif
  end

  ssd_hex_decoder u_dec (
    .nibble (nib),
    .dp     (dp_sel),
    .seg_c  (dec_seg)
  );

  // An out-of-range index leaves the bank dark
  always_comb begin
    seg_disp = (idx_valid && !blank) ? dec_seg : SEG_OFF;
    d_disp   = idx_valid ? ~(DIGITS'(1) << idx_adv) : '1;
  end

  // State and output registers; outputs change together only on a tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div        <= '0;
      idx        <= '0;
      running    <= 1'b0;
      stage_bin  <= '0;
      stage_dp   <= '0;
      shadow_bin <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      D_ssd      <= SEG_OFF;
      d          <= '1;
    end else begin
      div        <= div + 1'b1;
      shadow_bin <= shadow_bin_nxt;
      shadow_dp  <= shadow_dp_nxt;
      pending    <= pending_nxt;
      frame_done <= boundary;
      if (load) begin
        stage_bin <= bin;
        stage_dp  <= dp_in;
      end
      if (tick) begin
        running <= 1'b1;
        idx     <= idx_adv;
        D_ssd   <= seg_disp;
        d       <= d_disp;
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver with DIGITS=4, DIV_BITS=2 (4-clock
// slots, 16-clock frames). Expected {d, D_ssd} words are queued when the
// stimulus is applied and popped at each slot update.
module tb_ssd_scan_driver;

  logic        clk;
  logic        rst_n;
  logic [15:0] bin;
  logic [3:0]  dp_in;
  logic        load;
  logic [7:0]  D_ssd;
  logic [3:0]  d;
  logic        pending;
  logic        frame_done;

  int          errors;
  int          checks;
  int          edge_n;
  logic [11:0] exp_q[$];

  ssd_scan_driver #(
    .DIGITS   (4),
    .DIV_BITS (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bin        (bin),
    .dp_in      (dp_in),
    .load       (load),
    .D_ssd      (D_ssd),
    .d          (d),
    .pending    (pending),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Advance to 1 ns after posedge number n (counted from reset release)
  task automatic goto(input int n);
    while (edge_n < n) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
  endtask

  task automatic push(input logic [11:0] v);
    exp_q.push_back(v);
  endtask

  task automatic slot(input string tag);
    logic [11:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed %h expected <scoreboard empty>", tag, {d, D_ssd});
    end else begin
      e = exp_q.pop_front();
      chk(tag, {d, D_ssd}, e);
    end
  endtask

  // Pulse load so it is sampled on posedge n
  task automatic do_load(input int n, input logic [15:0] v, input logic [3:0] p);
    goto(n - 1);
    bin   = v;
    dp_in = p;
    load  = 1'b1;
    goto(n);
    load  = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    edge_n = 0;
    rst_n  = 1'b0;
    load   = 1'b0;
    bin    = '0;
    dp_in  = '0;

    // Reset held for three clocks
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_out", {d, D_ssd}, 12'hFFF);
    chk("rst_hold_pend", 12'(pending), 12'h0);
    chk("rst_hold_fd", 12'(frame_done), 12'h0);
    @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;

    // Dark until the first tick, then digit 0 shows "0"
    push(12'hFFF); push(12'hFFF); push(12'hFFF);
    goto(1); slot("dark_e1");
    goto(2); slot("dark_e2");
    goto(3); slot("dark_e3");
    push(12'hE03); push(12'hD03); push(12'hB03); push(12'h703); push(12'hE03);
    goto(4);  slot("first_d0");
    goto(8);  slot("first_d1");
    goto(12); slot("first_d2");
    goto(16); slot("first_d3");
    goto(20); slot("wrap_d0");
    chk("fd_wrap", 12'(frame_done), 12'h1);
    goto(21);
    chk("fd_pulse_end", 12'(frame_done), 12'h0);

    // Scan a mixed value with digit 2's point lit
    do_load(22, 16'h1A2F, 4'b0100);
    chk("scan_pend", 12'(pending), 12'h1);
    push(12'hD03); push(12'hB03); push(12'h703);
    push(12'hE71); push(12'hD25); push(12'hB10); push(12'h79F);
    goto(24); slot("scan_old_d1");
    goto(28); slot("scan_old_d2");
    goto(32); slot("scan_old_d3");
    goto(36); slot("scan_d0_F");
    chk("scan_fd", 12'(frame_done), 12'h1);
    chk("scan_pend_clr", 12'(pending), 12'h0);
    goto(40); slot("scan_d1_2");
    goto(44); slot("scan_d2_Adp");
    goto(48); slot("scan_d3_1");
    push(12'hE71);
    goto(52); slot("scan_rep_d0");

    // Mid-frame load must not tear the current frame
    do_load(54, 16'h1234, 4'b0000);
    chk("tear_pend", 12'(pending), 12'h1);
    push(12'hD25); push(12'hB10); push(12'h79F);
    push(12'hE99); push(12'hD0D); push(12'hB25); push(12'h79F);
    goto(56); slot("tear_old_d1");
    goto(60); slot("tear_old_d2");
    goto(64); slot("tear_old_d3");
    chk("tear_pend_hold", 12'(pending), 12'h1);
    goto(68); slot("tear_new_d0");
    chk("tear_fd", 12'(frame_done), 12'h1);
    chk("tear_pend_clr", 12'(pending), 12'h0);
    goto(72); slot("tear_new_d1");
    goto(76); slot("tear_new_d2");
    goto(80); slot("tear_new_d3");

    // Load on the boundary tick goes straight to the display
    do_load(84, 16'hBEEF, 4'b0000);
    chk("coll_pend", 12'(pending), 12'h0);
    push(12'hE71); push(12'hD61); push(12'hB61); push(12'h7C1);
    slot("coll_d0");
    chk("coll_fd", 12'(frame_done), 12'h1);
    goto(88); slot("coll_d1");
    goto(92); slot("coll_d2");
    goto(96); slot("coll_d3");

    // Two loads in one frame: only the last is displayed
    do_load(102, 16'h1111, 4'b0000);
    push(12'hD61); push(12'hB61); push(12'h7C1);
    push(12'hE25); push(12'hD25); push(12'hB25); push(12'h725);
    goto(104); slot("dbl_old_d1");
    goto(108); slot("dbl_old_d2");
    do_load(110, 16'h2222, 4'b0000);
    goto(112); slot("dbl_old_d3");
    goto(116); slot("dbl_d0");
    goto(120); slot("dbl_d1");
    goto(124); slot("dbl_d2");
    goto(128); slot("dbl_d3");

    // Leading-zero handling
    do_load(130, 16'h0050, 4'b0000);
    push(12'hE03); push(12'hD49);
`ifdef SSD_LEADING_ZERO_BLANK_EN
    push(12'hBFF); push(12'h7FF);
`else
    push(12'hB03); push(12'h703);
`endif
    goto(132); slot("lz_d0");
    goto(136); slot("lz_d1");
    goto(140); slot("lz_d2");
    goto(144); slot("lz_d3");
    chk("sb_drained", 12'(exp_q.size()), 12'h0);

    // Asynchronous reset mid-slot with a value pending
    do_load(147, 16'h9999, 4'b0000);
    chk("arst_pend_set", 12'(pending), 12'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_dark", {d, D_ssd}, 12'hFFF);
    chk("arst_pend", 12'(pending), 12'h0);
    chk("arst_fd", 12'(frame_done), 12'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ssd_scan_driver.md
# ssd_scan_driver

Parametrised time-multiplexed seven-segment driver for the board's common-anode display bank. Takes a packed vector of DIGITS hex nibbles plus per-digit decimal points and scans them one digit at a time at a divided refresh rate. Outputs are registered, and new values are applied only at frame boundaries so the display never tears. It sits between the lab datapath and the board pins, replacing single-digit static display wiring.

## Interface
- DIGITS, 4: number of digits scanned; 2..8.
- DIV_BITS, 16: width of the refresh divider; one digit slot lasts 2^DIV_BITS clocks.
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- bin  in  4*DIGITS  hex value; nibble k drives digit k; digit 0 is the rightmost.
- dp_in  in  DIGITS  decimal-point request per digit; 1 means lit.
- load  in  1  single-cycle strobe that captures bin and dp_in.
- D_ssd  out  8  segment bus {a,b,c,d,e,f,g,dp}; active-low (0 = segment lit).
- d  out  DIGITS  digit enables; active-low, exactly one 0 while scanning.
- pending  out  1  high while a captured value waits for the frame boundary.
- frame_done  out  1  one-cycle pulse when the last digit slot of a frame ends.

## Operation
- Divider counts 0..2^DIV_BITS-1 and wraps. The cycle where it equals all-ones is the tick.
- Digit index idx is 0..DIGITS-1. It advances on each tick and wraps from DIGITS-1 to 0. That wrap tick is the frame boundary.
- Two value registers:
  - staging: written on any cycle where load=1.
  - shadow: copied from staging at the frame boundary, only if pending=1.
- pending:
  - Set by load.
  - Cleared at the frame boundary copy.
  - If load coincides with the boundary tick, bin and dp_in go directly into shadow and pending stays 0.
  - Repeated loads before a boundary overwrite staging; the last load wins.
- Displayed digit = shadow nibble idx, hex-decoded, with dp = ~dp_shadow[idx].
- Hex patterns in {a..g}, active-low:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110
  - 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111
  - 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000
  - C = 0110001, d = 1000010, E = 0110000, F = 0111000
- d = ~(1 << idx).
- A digit index ≥ DIGITS is unreachable. If it is forced, d = all ones and D_ssd = 8'hFF.

## Timing
- Reset values:
  - divider = 0, idx = 0, staging = 0, shadow = 0, pending = 0, frame_done = 0.
  - D_ssd = 8'hFF and d = all ones (display dark).
- First display update is one cycle after the first tick. From then on, D_ssd and d update together, one cycle after each tick, and never independently.
- frame_done is asserted in the cycle following the boundary tick, aligned with the output update for digit 0.
- Shadow-to-output latency: the copy happens at the boundary tick, and new digit-0 pixels appear on the next cycle.
- Reset mid-frame forces the dark state immediately; any pending value is discarded.
- Full-frame period is DIGITS × 2^DIV_BITS clocks.

## Configuration
- SSD_LEADING_ZERO_BLANK_EN defined:
  - A digit k>0 is blanked (D_ssd = 8'hFF, d still asserted) when its shadow nibble and all more-significant nibbles are 0.
  - A lit dp on a digit suppresses blanking of that digit.
  - Digit 0 is never blanked.
- Macro undefined: every digit is always decoded.

## Structure
- Package ssd_pkg:
  - The 16 segment pattern constants.
  - SEG_OFF = 8'hFF.
  - typedef seg_t (8-bit segment bus).
- Sub-module ssd_hex_decoder: combinational 4-bit nibble plus dp to seg_t, using ssd_pkg constants. Instantiated once, fed by the mux of the shadow nibble at idx.
- Divider, index counter, staging/shadow/pending logic and output registers live in ssd_scan_driver.

## Test plan
All scenarios use DIGITS=4 and DIV_BITS=2 (4-clock digit slot, 16-clock frame).
- Reset: rst_n low for 3 clocks, then release → D_ssd = 8'hFF and d = 4'b1111 until the first tick; then d = 4'b1110 and D_ssd = 8'h03 (digit 0 showing "0", dp off).
- Scan: load bin = 16'h1A2F, dp_in = 4'b0100 → after the boundary, slots show F (8'h71), 2 (8'h25), A (8'h11) and 1 (8'h9F) with d = 1110, 1101, 1011, 0111; digit 2's dp is lit, so A shows as 8'h10.
- Tear-free: load 16'h1234 mid-frame → pending = 1, and the old value continues until the boundary; the new value appears with frame_done, and pending drops.
- Collision: load 16'hBEEF on the boundary tick → pending never rises; the next cycle shows F on digit 0. Two loads in one frame (16'h1111 then 16'h2222) → only 16'h2222 is ever displayed.
- Blanking: with SSD_LEADING_ZERO_BLANK_EN, load 16'h0050 → digits 3 and 2 show 8'hFF, digit 1 shows 5, digit 0 shows 0. Without the macro → digits 3 and 2 show "0".
- Async reset: assert rst_n mid-slot → outputs go dark the same cycle without waiting for clk, and pending clears.
